xor_fold_pipe: RTL and testbench

Pipelined, parametrised XOR-folding compactor for CH independent channels. Each IN_W-bit input word is folded by repeated upper-half/lower-half XOR down to OUT_W bits, one register stage per halving, behind a valid/ready handshake. Optional accumulate mode XOR-compacts a whole frame of beats into one signature word. Sits between wide datapath taps and narrow signature/compare logic; generalises the fixed 32→16, 2-channel combinational fold.

---
 rtl/xor_fold_pkg.sv | 31 +++
 rtl/xor_fold_stage.sv | 56 +++++
 rtl/xor_fold_pipe.sv | 140 ++++++++++++++
 tb/tb_xor_fold_pipe.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_fold_pkg.sv
// Shared helpers for the XOR-folding compactor: stage count, one halving step,
// and the ratio legality test used at elaboration.
package xor_fold_pkg;

  // Widest per-channel word any single halving step can take.
  localparam int unsigned FoldMaxW = 256;

  // True when in_w/out_w is an exact power of two and at least 2.
  function automatic bit is_pow2_ratio(int unsigned in_w, int unsigned out_w);
    int unsigned r;
    if (out_w == 0 || (in_w % out_w) != 0) return 1'b0;
    r = in_w / out_w;
    return (r >= 2) && ((r & (r - 1)) == 0);
  endfunction

  // Number of halvings needed to go from in_w down to out_w.
  function automatic int unsigned fold_stages(int unsigned in_w, int unsigned out_w);
    int unsigned s;
    s = 0;
    for (int unsigned r = in_w / out_w; r > 1; r = r >> 1) s++;
    return s;
  endfunction

  // One halving: y[i] = x[i] ^ x[i + w/2] for i < w/2, upper bits zero.
  function automatic logic [FoldMaxW-1:0] fold_half(logic [FoldMaxW-1:0] x, int unsigned w);
    logic [FoldMaxW-1:0] mask;
    mask = {FoldMaxW{1'b1}} >> (FoldMaxW - w / 2);
    return (x ^ (x >> (w / 2))) & mask;
  endfunction

endpackage

// File: rtl/xor_fold_stage.sv
// One halving step of the fold pipeline: CH channels of W bits in, W/2 bits out,
// registered together with the beat's valid/last/acc_mode sideband.
module xor_fold_stage
  import xor_fold_pkg::*;
#(
  parameter int unsigned CH = 2,
  parameter int unsigned W  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_i,
  input  logic                  valid_i,
  input  logic                  last_i,
  input  logic                  acc_i,
  input  logic [CH*W-1:0]       data_i,
  output logic                  valid_o,
  output logic                  last_o,
  output logic                  acc_o,
  output logic [CH*(W/2)-1:0]   data_o
);

  localparam int unsigned HalfW = W / 2;

  logic [CH*HalfW-1:0] data_d;
  logic [FoldMaxW-1:0] wide;
  logic [FoldMaxW-1:0] folded;

  // Fold every channel's word in half.
  always_comb begin
    data_d = '0;
    wide   = '0;
    folded = '0;
    for (int unsigned c = 0; c < CH; c++) begin
      wide          = '0;
      wide[W-1:0]   = data_i[c*W +: W];
      folded        = fold_half(wide, W);
      data_d[c*HalfW +: HalfW] = folded[HalfW-1:0];
    end
  end

  // Stage register; holds everything while the pipeline is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o <= 1'b0;
      last_o  <= 1'b0;
      acc_o   <= 1'b0;
      data_o  <= '0;
    end else if (en_i) begin
      valid_o <= valid_i;
      last_o  <= last_i;
      acc_o   <= acc_i;
      data_o  <= data_d;
    end
  end

endmodule

// File: rtl/xor_fold_pipe.sv
// Pipelined XOR-folding compactor for CH channels, IN_W -> OUT_W bits per channel,
// one register stage per halving, single global stall behind valid/ready.
// Define XOR_FOLD_ACC_EN to compile in frame accumulation (acc_mode).
module xor_fold_pipe
  import xor_fold_pkg::*;
#(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned CH    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CH*IN_W-1:0]    in_data,
  input  logic                  in_last,
  input  logic                  acc_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CH*OUT_W-1:0]   out_data,
  output logic                  out_last
);

  localparam int unsigned Stages = fold_stages(IN_W, OUT_W);

  if (!is_pow2_ratio(IN_W, OUT_W) || IN_W > FoldMaxW) begin : gen_bad_cfg
    $error("xor_fold_pipe: IN_W/OUT_W must be a power of two >= 2 and IN_W <= FoldMaxW");
  end

  logic en;
  logic in_fire;

  // All stage outputs packed back to back; stage s output starts at CH*(IN_W - (IN_W>>s)).
  logic [CH*(IN_W-OUT_W)-1:0] fold_bus;
  logic [Stages-1:0]          stg_valid;
  logic [Stages-1:0]          stg_last;
  logic [Stages-1:0]          stg_acc;

  logic                fin_valid;
  logic                fin_last;
  logic                fin_acc;
  logic [CH*OUT_W-1:0] fin_data;
  logic                head_acc;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign in_fire  = in_valid && en;

`ifdef XOR_FOLD_ACC_EN
  assign head_acc = acc_mode;
`else
  assign head_acc = 1'b0;
`endif

  for (genvar s = 0; s < Stages; s++) begin : gen_stage
    localparam int unsigned Ws     = IN_W >> s;
    localparam int unsigned OutOff = CH * (IN_W - Ws);

    logic [CH*Ws-1:0] d_in;
    logic             v_in;
    logic             l_in;
    logic             a_in;

    if (s == 0) begin : gen_head
      assign d_in = in_data;
      assign v_in = in_fire;
      assign l_in = in_last;
      assign a_in = head_acc;
    end else begin : gen_body
      localparam int unsigned InOff = CH * (IN_W - 2 * Ws);
      assign d_in = fold_bus[InOff +: CH*Ws];
      assign v_in = stg_valid[s-1];
      assign l_in = stg_last[s-1];
      assign a_in = stg_acc[s-1];
    end

    xor_fold_stage #(
      .CH (CH),
      .W  (Ws)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en_i    (en),
      .valid_i (v_in),
      .last_i  (l_in),
      .acc_i   (a_in),
      .data_i  (d_in),
      .valid_o (stg_valid[s]),
      .last_o  (stg_last[s]),
      .acc_o   (stg_acc[s]),
      .data_o  (fold_bus[OutOff +: CH*(Ws/2)])
    );
  end

  assign fin_valid = stg_valid[Stages-1];
  assign fin_last  = stg_last[Stages-1];
  assign fin_acc   = stg_acc[Stages-1];
  assign fin_data  = fold_bus[CH*(IN_W-2*OUT_W) +: CH*OUT_W];
  assign out_last  = fin_last;

`ifdef XOR_FOLD_ACC_EN
  logic [CH*OUT_W-1:0] acc_q;
  logic [CH*OUT_W-1:0] acc_d;
  logic                unused_acc_mode;

  assign unused_acc_mode = 1'b0;

  // Non-last accumulate beats are absorbed; the last beat emits acc ^ beat.
  always_comb begin
    out_valid = fin_valid && !(fin_acc && !fin_last);
    out_data  = fin_data;
    if (fin_acc && fin_last) out_data = acc_q ^ fin_data;
  end

  // Accumulator advances only when the output-stage beat retires.
  always_comb begin
    acc_d = acc_q;
    if (fin_valid && fin_acc && en) begin
      acc_d = fin_last ? '0 : (acc_q ^ fin_data);
    end
  end

  // Accumulator register; per-channel XOR is the same as whole-word XOR.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`else
  logic unused_acc_mode;

  // acc_mode has no effect in this build.
  assign unused_acc_mode = acc_mode ^ fin_acc;
  assign out_valid       = fin_valid;
  assign out_data        = fin_data;
`endif

endmodule

// File: tb/tb_xor_fold_pipe.sv
// Self-checking bench for xor_fold_pipe: directed cases plus randomized traffic
// checked every cycle against a queue-based fold model.
module tb_xor_fold_pipe;

  localparam int unsigned IN_W  = 32;
  localparam int unsigned OUT_W = 16;
  localparam int unsigned CH    = 2;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [CH*IN_W-1:0]  in_data;
  logic                in_last;
  logic                acc_mode;
  logic                out_valid;
  logic                out_ready;
  logic [CH*OUT_W-1:0] out_data;
  logic                out_last;

  // Second instance: 64 -> 16, one channel.
  logic        v64;
  logic        ir64;
  logic [63:0] d64;
  logic        ov64;
  logic        r64;
  logic [15:0] od64;
  logic        ol64;
  logic        zero_bit;

  int n_checks = 0;
  int n_fail   = 0;
  int n_out    = 0;

  logic [CH*OUT_W:0]   exp_q[$];
  logic [CH*OUT_W-1:0] model_acc;
  logic [CH*OUT_W-1:0] last_data;
  logic                last_last;
  logic                stall_prev;
  logic [CH*OUT_W-1:0] stall_data;

  xor_fold_pipe #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W),
    .CH    (CH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .acc_mode  (acc_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  xor_fold_pipe #(
    .IN_W  (64),
    .OUT_W (16),
    .CH    (1)
  ) dut64 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (v64),
    .in_ready  (ir64),
    .in_data   (d64),
    .in_last   (zero_bit),
    .acc_mode  (zero_bit),
    .out_valid (ov64),
    .out_ready (r64),
    .out_data  (od64),
    .out_last  (ol64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: out[i] = XOR over k of in[i + k*OUT_W].
  function automatic logic [OUT_W-1:0] fold_word(logic [IN_W-1:0] x);
    logic [OUT_W-1:0] r;
    r = '0;
    for (int k = 0; k < int'(IN_W / OUT_W); k++) r ^= x[k*OUT_W +: OUT_W];
    return r;
  endfunction

  function automatic logic [CH*OUT_W-1:0] fold_beat(logic [CH*IN_W-1:0] x);
    logic [CH*OUT_W-1:0] r;
    r = '0;
    for (int c = 0; c < int'(CH); c++) r[c*OUT_W +: OUT_W] = fold_word(x[c*IN_W +: IN_W]);
    return r;
  endfunction

  function automatic logic [15:0] fold64(logic [63:0] x);
    return x[15:0] ^ x[31:16] ^ x[47:32] ^ x[63:48];
  endfunction

  // Monitor/scoreboard, sampled mid-cycle where all signals are settled.
  always @(negedge clk) begin
    logic [CH*OUT_W:0]   e;
    logic [CH*OUT_W-1:0] f;
    if (rst) begin
      exp_q.delete();
      model_acc  = '0;
      stall_prev = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (stall_prev) begin
        check("stall_valid_held", out_valid, 1'b1);
        check("stall_data_held", out_data, stall_data);
      end
      if (out_valid && out_ready) begin
        n_out++;
        last_data = out_data;
        last_last = out_last;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out: got data 0x%0h expected no beat", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e[CH*OUT_W-1:0] || out_last !== e[CH*OUT_W]) begin
            n_fail++;
            $display("FAIL out_beat: got last=%0b data=0x%0h expected last=%0b data=0x%0h",
                     out_last, out_data, e[CH*OUT_W], e[CH*OUT_W-1:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        f = fold_beat(in_data);
`ifdef XOR_FOLD_ACC_EN
        if (acc_mode) begin
          if (!in_last) begin
            model_acc = model_acc ^ f;
          end else begin
            exp_q.push_back({1'b1, model_acc ^ f});
            model_acc = '0;
          end
        end else begin
          exp_q.push_back({in_last, f});
        end
`else
        exp_q.push_back({in_last, f});
`endif
      end
      stall_prev = out_valid && !out_ready;
      stall_data = out_data;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [CH*IN_W-1:0] d, input logic l, input logic a);
    bit done;
    int guard;
    done  = 1'b0;
    guard = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    acc_mode = a;
    while (!done) begin
      @(negedge clk);
      done = in_ready;
      step();
      guard++;
      if (!done && guard > 100) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: got no in_ready expected accept within 100 cycles");
        done = 1'b1;
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected test end");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [63:0] b64[4];

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; acc_mode = 1'b0;
    out_ready = 1'b1; v64 = 1'b0; d64 = '0; r64 = 1'b1; zero_bit = 1'b0;
    model_acc = '0; last_data = '0; last_last = 1'b0; stall_prev = 1'b0; stall_data = '0;

    // Model pinned to hand-computed values.
    check("pin_fold_default", fold_beat({32'hFFFF_0000, 32'h1234_5678}), 32'hFFFF_444C);
    check("pin_fold64", fold64(64'h0001_0002_0004_0008), 16'h000F);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    step();
    rst = 1'b0;
    step();

    // Basic fold, one-cycle latency with one stage.
    send({32'hFFFF_0000, 32'h1234_5678}, 1'b0, 1'b0);
    check("lat1_valid", out_valid, 1'b1);
    check("lat1_data", out_data, 32'hFFFF_444C);
    step();

    // Stall: output frozen, in_ready low, then drains with in_ready back high.
    out_ready = 1'b0;
    send({32'hA5A5_0F0F, 32'hDEAD_BEEF}, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_out_valid", out_valid, 1'b1);
      check("stall_in_ready", in_ready, 1'b0);
      check("stall_out_data", out_data, {16'hA5A5 ^ 16'h0F0F, 16'hDEAD ^ 16'hBEEF});
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("release_in_ready", in_ready, 1'b1);
    check("release_out_last", out_last, 1'b1);
    step();
    @(negedge clk);
    check("drained_valid", out_valid, 1'b0);
    step();

`ifdef XOR_FOLD_ACC_EN
    base = n_out;
    send({32'h0, 32'h0001_0000}, 1'b0, 1'b1);
    send({32'h0, 32'h0000_0002}, 1'b0, 1'b1);
    send({32'h0, 32'h0004_0000}, 1'b1, 1'b1);
    repeat (3) step();
    check("acc_frame_count", n_out - base, 1);
    check("acc_frame_data", last_data, 32'h0000_0007);
    check("acc_frame_last", last_last, 1'b1);
    send({32'h0, 32'h0000_0003}, 1'b1, 1'b1);
    repeat (3) step();
    check("acc_next_frame", last_data, 32'h0000_0003);

    // Reset mid-frame discards the partial accumulation.
    send({32'h0, 32'h0100_0000}, 1'b0, 1'b1);
    send({32'h0, 32'h0000_0020}, 1'b0, 1'b1);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    base = n_out;
    send({32'h0, 32'h0000_0010}, 1'b1, 1'b1);
    repeat (3) step();
    check("acc_rst_count", n_out - base, 1);
    check("acc_rst_data", last_data, 32'h0000_0010);
`else
    base = n_out;
    send({32'h0000_1111, 32'h0001_0000}, 1'b0, 1'b1);
    send({32'h2222_0000, 32'h0000_0002}, 1'b0, 1'b1);
    send({32'h4444_0001, 32'h0004_0000}, 1'b1, 1'b1);
    repeat (3) step();
    check("noacc_count", n_out - base, 3);
    check("noacc_last_data", last_data, 32'h4445_0004);
    check("noacc_last_flag", last_last, 1'b1);
`endif

    // 64 -> 16: two stages, two-cycle latency.
    v64 = 1'b1;
    d64 = 64'h0001_0002_0004_0008;
    @(negedge clk);
    check("w64_in_ready", ir64, 1'b1);
    step();
    v64 = 1'b0;
    @(negedge clk);
    check("w64_not_yet", ov64, 1'b0);
    step();
    @(negedge clk);
    check("w64_valid", ov64, 1'b1);
    check("w64_data", od64, 16'h000F);
    check("w64_last", ol64, 1'b0);
    step();

    // Back-to-back beats come out one per cycle.
    for (int i = 0; i < 4; i++) b64[i] = {$urandom, $urandom};
    for (int j = 0; j < 6; j++) begin
      if (j < 4) begin
        v64 = 1'b1;
        d64 = b64[j];
      end else begin
        v64 = 1'b0;
      end
      @(negedge clk);
      if (j >= 2) begin
        check("w64_b2b_valid", ov64, 1'b1);
        check("w64_b2b_data", od64, fold64(b64[j-2]));
      end
      step();
    end

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < 400; i++) begin
      rst       = (i == 200);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = {$urandom, $urandom};
      in_last   = ($urandom_range(0, 3) == 0);
      acc_mode  = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (5) step();
    check("final_drain", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
